// File: rtl/dit_fft_ctrl_pkg.sv
// Shared constants, load-FSM states and index helper for the 8-point DIT FFT sequencer.
package dit_fft_ctrl_pkg;

   localparam int N_PTS = 8;
   localparam int IDX_W = 3;

   typedef enum logic [1:0] {
      FILL    = 2'd0,
      COMPUTE = 2'd1,
      WAIT    = 2'd2
   } load_st_t;

   // Sample/bin indices wrap naturally at N_PTS.
   function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
      return idx + IDX_W'(1);
   endfunction

endpackage

// File: rtl/dit_fft_ctrl_obuf.sv
// Output frame register file and drain logic.
// Presents captured core results in natural bin order and counts drained frames.
module dit_fft_ctrl_obuf
   import dit_fft_ctrl_pkg::*;
#(
   parameter int DW = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                capture,
   input  logic [N_PTS*DW-1:0] core_xk,
   input  logic                m_ready,
   output logic                m_valid,
   output logic [DW-1:0]       m_data,
   output logic [IDX_W-1:0]    m_index,
   output logic                m_last,
   output logic [15:0]         frame_cnt,
   output logic                free
);

   logic [DW-1:0] out_buf [N_PTS];

   assign m_data = out_buf[m_index];
   assign m_last = m_valid && (m_index == IDX_W'(N_PTS-1));
   assign free   = !m_valid || (m_ready && m_last);

   // A capture wins over the last-beat clear, so back-to-back frames leave no valid gap.
   always_ff @(posedge clk) begin
      if (rst) begin
         m_valid   <= 1'b0;
         m_index   <= '0;
         frame_cnt <= '0;
         for (int k = 0; k < N_PTS; k++) out_buf[k] <= '0;
      end else begin
         if (m_valid && m_ready) begin
            m_index <= next_idx(m_index);
            if (m_last) begin
               frame_cnt <= frame_cnt + 16'd1;
               m_valid   <= 1'b0;
            end
         end
         if (capture) begin
            for (int k = 0; k < N_PTS; k++) out_buf[k] <= core_xk[k*DW +: DW];
            m_valid <= 1'b1;
            m_index <= '0;
         end
      end
   end

endmodule

// File: rtl/dit_fft_ctrl.sv
// Streaming sequencer for the 8-point combinational dit_fft core.
// Loads a frame, holds it on the core for CORE_LAT cycles, then hands results to the output buffer.
module dit_fft_ctrl
   import dit_fft_ctrl_pkg::*;
#(
   parameter int DW       = 32,
   parameter int CORE_LAT = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                s_valid,
   output logic                s_ready,
   input  logic [DW-1:0]       s_data,
   output logic [N_PTS*DW-1:0] core_xn,
   input  logic [N_PTS*DW-1:0] core_xk,
   output logic                m_valid,
   input  logic                m_ready,
   output logic [DW-1:0]       m_data,
   output logic [IDX_W-1:0]    m_index,
   output logic                m_last,
   output logic [15:0]         frame_cnt,
   output logic                busy
);

   localparam int CW = (CORE_LAT > 1) ? $clog2(CORE_LAT) : 1;

   load_st_t         load_st, load_nx;
   logic [IDX_W-1:0] in_idx;
   logic [CW-1:0]    lat_cnt;
   logic [DW-1:0]    in_buf [N_PTS];
   logic             s_fire, lat_done, capture, free;

   assign s_ready  = (load_st == FILL) && !rst;
   assign s_fire   = s_valid && s_ready;
   assign lat_done = (lat_cnt == CW'(CORE_LAT-1));
   assign busy     = (load_st != FILL) || (in_idx != '0) || m_valid;

   for (genvar k = 0; k < N_PTS; k++) begin : g_xn
      assign core_xn[k*DW +: DW] = in_buf[k];
   end

   // Capture only when the output buffer can take a whole frame; otherwise park in WAIT.
   always_comb begin
      load_nx = load_st;
      capture = 1'b0;
      case (load_st)
         FILL: begin
            if (s_fire && (in_idx == IDX_W'(N_PTS-1))) load_nx = COMPUTE;
         end
         COMPUTE: begin
            if (lat_done) begin
               if (free) begin
                  capture = 1'b1;
                  load_nx = FILL;
               end else begin
                  load_nx = WAIT;
               end
            end
         end
         WAIT: begin
            if (free) begin
               capture = 1'b1;
               load_nx = FILL;
            end
         end
         default: load_nx = FILL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         load_st <= FILL;
         in_idx  <= '0;
         lat_cnt <= '0;
         for (int k = 0; k < N_PTS; k++) in_buf[k] <= '0;
      end else begin
         load_st <= load_nx;
         if (s_fire) begin
            in_buf[in_idx] <= s_data;
            in_idx         <= next_idx(in_idx);
         end
         lat_cnt <= (load_st == COMPUTE && !lat_done) ? lat_cnt + CW'(1) : '0;
      end
   end

   dit_fft_ctrl_obuf #(.DW(DW)) u_obuf (
      .clk       (clk),
      .rst       (rst),
      .capture   (capture),
      .core_xk   (core_xk),
      .m_ready   (m_ready),
      .m_valid   (m_valid),
      .m_data    (m_data),
      .m_index   (m_index),
      .m_last    (m_last),
      .frame_cnt (frame_cnt),
      .free      (free)
   );

endmodule

// File: tb/tb_dit_fft_ctrl.sv
// Self-checking bench for dit_fft_ctrl with a stand-in combinational core.
// The stand-in core outputs xk[k] = xn[bitrev(k)] + k, so every bin is distinct and order-sensitive.
module tb_dit_fft_ctrl;
   import dit_fft_ctrl_pkg::*;

   typedef logic [7:0][31:0] frame_t;
   typedef struct packed {
      frame_t xn;
      frame_t xk;
   } vec_t;

   logic        clk, rst, s_valid, s_ready, m_valid, m_ready, m_last, busy;
   logic [31:0] s_data, m_data;
   logic [2:0]  m_index;
   logic [15:0] frame_cnt;
   frame_t      core_xn, core_xk;

   int          checks = 0, failures = 0, cyc = 0;
   logic [31:0] exp_q [$];
   logic [31:0] exp_val;
   int          exp_idx = 0, beats = 0, rdy_mode = 0;
   int          srdy_low = 0, wait_seen = 0, gap_cnt = 0;
   bit          win_en = 0, gap_en = 0;
   vec_t        tbl [4];

   dit_fft_ctrl #(.DW(32), .CORE_LAT(1)) dut (
      .clk       (clk),
      .rst       (rst),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .s_data    (s_data),
      .core_xn   (core_xn),
      .core_xk   (core_xk),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_data    (m_data),
      .m_index   (m_index),
      .m_last    (m_last),
      .frame_cnt (frame_cnt),
      .busy      (busy)
   );

   function automatic logic [31:0] core_lane(input frame_t xn, input int k);
      logic [2:0] kk;
      kk = 3'(k);
      return xn[{kk[0], kk[1], kk[2]}] + 32'(k);
   endfunction

   function automatic frame_t golden(input frame_t xn);
      frame_t g;
      for (int k = 0; k < 8; k++) g[k] = core_lane(xn, k);
      return g;
   endfunction

   function automatic frame_t rand_frame();
      frame_t r;
      for (int i = 0; i < 8; i++) r[i] = $urandom;
      return r;
   endfunction

   always_comb begin
      for (int k = 0; k < 8; k++) core_xk[k] = core_lane(core_xn, k);
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial m_ready = 1'b0;
   always @(posedge clk) begin
      #2;
      case (rdy_mode)
         0:       m_ready = 1'b1;
         1:       m_ready = 1'b0;
         default: m_ready = 1'($urandom_range(0, 1));
      endcase
   end

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // Output scoreboard: every accepted beat must match the next expected bin in order.
   always @(negedge clk) begin
      if (!rst && m_valid && m_ready) begin
         if (exp_q.size() == 0) begin
            check_output("unexpected_beat", 32'(m_index), 32'hFFFF_FFFF);
         end else begin
            exp_val = exp_q.pop_front();
            check_output("m_data", m_data, exp_val);
            check_output("m_index", 32'(m_index), 32'(exp_idx));
            check_output("m_last", 32'(m_last), (exp_idx == 7) ? 32'd1 : 32'd0);
            exp_idx = (exp_idx + 1) % 8;
            beats++;
         end
      end
      if (win_en) begin
         if (!s_ready) srdy_low++;
         if (dut.load_st == WAIT) wait_seen++;
      end
      if (gap_en && !m_valid) gap_cnt++;
   end

   task automatic send_beat(input logic [31:0] d);
      int n;
      bit ok;
      n = 0;
      ok = 0;
      s_valid = 1'b1;
      s_data  = d;
      while (!ok && n < 200) begin
         @(negedge clk);
         if (s_ready) ok = 1;
         @(posedge clk);
         #1;
         n++;
      end
      if (!ok) check_output("s_ready_timeout", 32'd0, 32'd1);
   endtask

   task automatic apply_stimulus(input frame_t xn, input frame_t xk);
      for (int i = 0; i < 8; i++) send_beat(xn[i]);
      for (int k = 0; k < 8; k++) exp_q.push_back(xk[k]);
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || m_valid) && n < 5000) begin
         @(posedge clk);
         #1;
         n++;
      end
      check_output("drain_in_time", (n < 5000) ? 32'd1 : 32'd0, 32'd1);
   endtask

   task automatic do_reset();
      rst     = 1'b1;
      s_valid = 1'b0;
      exp_q.delete();
      exp_idx = 0;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      #3_000_000;
      $display("[TB] FAIL global_timeout: got running expected finished");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      frame_t f1, f2, fr;
      int     acc_cyc, n, fc0;

      tbl[0].xn = {32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1};
      tbl[0].xk = {32'd15, 32'd10, 32'd11, 32'd6, 32'd10, 32'd5, 32'd6, 32'd1};
      tbl[1].xn = {32'h70, 32'h60, 32'h50, 32'h40, 32'h30, 32'h20, 32'h10, 32'h0};
      tbl[1].xk = {32'h77, 32'h36, 32'h55, 32'h14, 32'h63, 32'h22, 32'h41, 32'h0};
      tbl[2].xn = {8{32'hFFFF_FFFF}};
      tbl[2].xk = {32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1, 32'd0, 32'hFFFF_FFFF};
      tbl[3].xn = {32'd18, 32'd17, 32'd16, 32'd15, 32'd14, 32'd13, 32'd12, 32'd11};
      tbl[3].xk = {32'd25, 32'd20, 32'd21, 32'd16, 32'd20, 32'd15, 32'd16, 32'd11};

      rst = 1'b1;
      s_valid = 1'b0;
      s_data = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_output("rst_s_ready", 32'(s_ready), 32'd0);
      check_output("rst_m_valid", 32'(m_valid), 32'd0);
      check_output("rst_busy", 32'(busy), 32'd0);
      check_output("rst_frame_cnt", 32'(frame_cnt), 32'd0);
      check_output("rst_m_index", 32'(m_index), 32'd0);
      check_output("rst_m_last", 32'(m_last), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check_output("post_rst_s_ready", 32'(s_ready), 32'd1);
      @(posedge clk);
      #1;

      // Directed frame 1..8: core input packing and first-result latency.
      apply_stimulus(tbl[0].xn, tbl[0].xk);
      acc_cyc = cyc - 1;
      s_valid = 1'b0;
      check_output("core_xn_packed", (core_xn === tbl[0].xn) ? 32'd1 : 32'd0, 32'd1);
      @(negedge clk);
      check_output("compute_m_valid", 32'(m_valid), 32'd0);
      check_output("compute_s_ready", 32'(s_ready), 32'd0);
      check_output("compute_busy", 32'(busy), 32'd1);
      n = 0;
      while (!m_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      check_output("m_valid_latency", 32'(cyc - acc_cyc), 32'd2);
      @(posedge clk);
      #1;
      wait_drain();
      check_output("frame_cnt_t1", 32'(frame_cnt), 32'd1);

      for (int i = 1; i < 3; i++) begin
         apply_stimulus(tbl[i].xn, tbl[i].xk);
         s_valid = 1'b0;
         wait_drain();
         check_output("frame_cnt_tbl", 32'(frame_cnt), 32'(1 + i));
      end

      // Back-to-back random frames: no WAIT, one s_ready-low cycle per frame.
      fc0 = int'(frame_cnt);
      srdy_low = 0;
      wait_seen = 0;
      win_en = 1;
      for (int i = 0; i < 4; i++) begin
         fr = rand_frame();
         apply_stimulus(fr, golden(fr));
      end
      s_valid = 1'b0;
      wait_drain();
      win_en = 0;
      check_output("b2b_s_ready_low", 32'(srdy_low), 32'd4);
      check_output("b2b_wait_seen", 32'(wait_seen), 32'd0);
      check_output("b2b_frame_cnt", 32'(frame_cnt), 32'(fc0 + 4));

      // Downstream stall: second frame must park in WAIT behind the first.
      fc0 = int'(frame_cnt);
      rdy_mode = 1;
      repeat (2) @(posedge clk);
      #1;
      f1 = rand_frame();
      f2 = rand_frame();
      apply_stimulus(f1, golden(f1));
      apply_stimulus(f2, golden(f2));
      s_valid = 1'b0;
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_output("stall_in_wait", 32'(dut.load_st), 32'(WAIT));
         check_output("stall_s_ready", 32'(s_ready), 32'd0);
         check_output("stall_m_data", m_data, golden(f1)[0]);
         check_output("stall_m_index", 32'(m_index), 32'd0);
      end
      @(posedge clk);
      #1;
      rdy_mode = 0;
      gap_cnt = 0;
      gap_en = 1;
      wait_drain();
      gap_en = 0;
      check_output("release_valid_gap", 32'(gap_cnt), 32'd0);
      check_output("release_frame_cnt", 32'(frame_cnt), 32'(fc0 + 2));

      // Reset in the middle of a frame discards the partial samples.
      for (int i = 0; i < 5; i++) send_beat(32'hDEAD_0000 + 32'(i));
      rst = 1'b1;
      s_valid = 1'b0;
      exp_q.delete();
      exp_idx = 0;
      @(negedge clk);
      check_output("midrst_s_ready", 32'(s_ready), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check_output("midrst_s_ready_after", 32'(s_ready), 32'd1);
      check_output("midrst_busy", 32'(busy), 32'd0);
      check_output("midrst_frame_cnt", 32'(frame_cnt), 32'd0);
      n = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (m_valid) n++;
      end
      check_output("midrst_no_output", 32'(n), 32'd0);
      @(posedge clk);
      #1;
      apply_stimulus(tbl[3].xn, tbl[3].xk);
      s_valid = 1'b0;
      wait_drain();
      check_output("midrst_frame_cnt_after", 32'(frame_cnt), 32'd1);

      // Long run with random downstream backpressure.
      do_reset();
      beats = 0;
      rdy_mode = 2;
      for (int i = 0; i < 1000; i++) begin
         fr = rand_frame();
         apply_stimulus(fr, golden(fr));
      end
      s_valid = 1'b0;
      wait_drain();
      rdy_mode = 0;
      check_output("long_frame_cnt", 32'(frame_cnt), 32'd1000);
      check_output("long_beats", 32'(beats), 32'd8000);
      check_output("long_queue_empty", 32'(exp_q.size()), 32'd0);

      // Frame counter wrap from 65535.
      @(posedge clk);
      #1;
      force dut.u_obuf.frame_cnt = 16'hFFFF;
      @(posedge clk);
      #1;
      release dut.u_obuf.frame_cnt;
      @(negedge clk);
      check_output("wrap_preload", 32'(frame_cnt), 32'hFFFF);
      @(posedge clk);
      #1;
      apply_stimulus(tbl[1].xn, tbl[1].xk);
      s_valid = 1'b0;
      wait_drain();
      check_output("wrap_frame_cnt", 32'(frame_cnt), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
